// File: rtl/lamp_ctrl_n.sv
// rtl/lamp_ctrl_n.sv - multi-switch staircase lamp with synchroniser, debounce and auto-off
module lamp_ctrl_n #(
  parameter int N_SW         = 3,
  parameter int DEBOUNCE_CYC = 4,
  parameter int TIMEOUT_CYC  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] S,
  output logic            F,
  output logic [N_SW-1:0] sw_db,
  output logic            toggle,
  output logic            timeout
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [N_SW-1:0] s1;
  logic [N_SW-1:0] s2;
  logic [N_SW-1:0] db_next;
  logic [N_SW-1:0] upd;
  logic [CW-1:0]   cnt      [N_SW];
  logic [CW-1:0]   cnt_next [N_SW];
  logic            ev;
  logic            expire;

  // Two-flop synchroniser for the raw, asynchronous switch levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= S;
      s2 <= s1;
    end
  end

  // Per-bit debounce decision: accept a level once it has disagreed for DEBOUNCE_CYC samples.
  always_comb begin
    db_next = sw_db;
    upd     = '0;
    for (int i = 0; i < N_SW; i++) begin
      cnt_next[i] = cnt[i];
      if (s2[i] == sw_db[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        db_next[i]  = s2[i];
        cnt_next[i] = '0;
        upd[i]      = 1'b1;
      end else begin
        cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  // Debounce state: counters and accepted switch levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_db <= '0;
      for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
    end else begin
      sw_db <= db_next;
      for (int i = 0; i < N_SW; i++) cnt[i] <= cnt_next[i];
    end
  end

  // An odd number of simultaneous accepted changes flips the lamp; even counts cancel.
  assign ev = ^upd;

  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      localparam int TW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
      logic [TW-1:0] tmr;

      // A switch event takes priority over expiry on the same edge.
      assign expire = !ev && F && (tmr == TMR_LAST);

      // Lamp on-time counter, restarted by every switch event and idle while the lamp is off.
      always_ff @(posedge clk) begin
        if (rst) begin
          tmr <= '0;
        end else if (ev || !F || expire) begin
          tmr <= '0;
        end else begin
          tmr <= tmr + TW'(1);
        end
      end
    end else begin : g_no_timer
      assign expire = 1'b0;
    end
  endgenerate

  // Lamp output and its one-cycle event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      F       <= 1'b0;
      toggle  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      toggle  <= ev;
      timeout <= expire;
      if (ev) begin
        F <= ~F;
      end else if (expire) begin
        F <= 1'b0;
      end
    end
  end

endmodule
